// File: rtl/xyz_ctrl_pkg.sv
// Shared definitions for the xyz step controller and the xyz phase FSM:
// controller state encoding, phase-to-xyz output encoding, default parameters.
package xyz_ctrl_pkg;

    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_DWELL = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    // One-hot-ish xyz FSM outputs for phases 0..3
    localparam logic [2:0] XYZ_P0 = 3'b000;
    localparam logic [2:0] XYZ_P1 = 3'b001;
    localparam logic [2:0] XYZ_P2 = 3'b010;
    localparam logic [2:0] XYZ_P3 = 3'b100;

    function automatic logic [2:0] phase_to_xyz(input logic [1:0] p);
        logic [2:0] enc;
        case (p)
            2'd0:    enc = XYZ_P0;
            2'd1:    enc = XYZ_P1;
            2'd2:    enc = XYZ_P2;
            default: enc = XYZ_P3;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/xyz_rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not served last wins a tie.
module xyz_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the pointer picks the other side
    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/xyz_step_ctrl.sv
// Sequencer for the 4-phase xyz FSM: arbitrates two step requesters, issues
// one-cycle advance strobes separated by DWELL hold cycles, tracks phase.
// Optional feature: define XYZ_CTRL_PHASE_CHECK_EN to compare xyz_fb against
// the expected phase and raise a sticky phase_err.
module xyz_step_ctrl
    import xyz_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [CNT_W-1:0] req0_cnt,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic             req1_ready,
    output logic             seq_i,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    input  logic [2:0]       xyz_fb,
    output logic             phase_err
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    ctrl_state_t      state;
    logic [CNT_W-1:0] cnt_rem;
    logic [DW_W-1:0]  dwell_cnt;
    logic             owner;
    logic             last;
    logic [1:0]       grant;
    logic [CNT_W-1:0] sel_cnt;

    xyz_rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .grant (grant)
    );

    assign sel_cnt = grant[1] ? req1_cnt : req0_cnt;

    // Ready only while idle and not held in reset
    assign req0_ready = ~rst & (state == ST_IDLE) & grant[0];
    assign req1_ready = ~rst & (state == ST_IDLE) & grant[1];

    // Status outputs decode directly from the state register
    assign seq_i   = (state != ST_STEP);
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_DONE);
    assign done_id = (state == ST_DONE) & owner;

    // Controller FSM with command, dwell and phase bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt_rem   <= '0;
            dwell_cnt <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            phase     <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        owner   <= grant[1];
                        cnt_rem <= sel_cnt;
                        state   <= (sel_cnt == '0) ? ST_DONE : ST_STEP;
                    end
                end
                ST_STEP: begin
                    phase   <= phase + 2'd1;
                    cnt_rem <= cnt_rem - CNT_W'(1);
                    if (cnt_rem == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end else begin
                        dwell_cnt <= DW_W'(DWELL - 1);
                        state     <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt == '0) begin
                        state <= ST_STEP;
                    end else begin
                        dwell_cnt <= dwell_cnt - DW_W'(1);
                    end
                end
                ST_DONE: begin
                    last  <= owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef XYZ_CTRL_PHASE_CHECK_EN
    // Sticky flag when the xyz FSM disagrees with the expected phase outside STEP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_err <= 1'b0;
        end else if ((state != ST_STEP) && (xyz_fb != phase_to_xyz(phase))) begin
            phase_err <= 1'b1;
        end
    end
`else
    logic unused_xyz_fb;
    assign unused_xyz_fb = ^xyz_fb;
    assign phase_err     = 1'b0;
`endif

endmodule

// File: tb/tb_xyz_step_ctrl.sv
// Self-checking bench for xyz_step_ctrl: directed scenarios plus randomized
// command streams checked against a schedule model derived from the timing rules.
module tb_xyz_step_ctrl;

    localparam int unsigned CW = 8;
    localparam int unsigned D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [CW-1:0] req0_cnt, req1_cnt;
    logic          req0_ready, req1_ready;
    logic          seq_i, busy, done, done_id, phase_err;
    logic [1:0]    phase;
    logic [2:0]    xyz_fb;

    logic          fb_bad;
    logic [1:0]    fb_phase;

    int n_cmp = 0;
    int n_bad = 0;
    int model_phase;
    int model_last;

    xyz_step_ctrl #(.CNT_W(CW), .DWELL(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_cnt   (req0_cnt),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_cnt   (req1_cnt),
        .req1_ready (req1_ready),
        .seq_i      (seq_i),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .xyz_fb     (xyz_fb),
        .phase_err  (phase_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] enc(input int p);
        case (p % 4)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Stand-in for the xyz phase FSM: advances whenever I=0 at a clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) fb_phase <= 2'd0;
        else if (!seq_i) fb_phase <= fb_phase + 2'd1;
    end
    assign xyz_fb = fb_bad ? 3'b011 : enc(int'(fb_phase));

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_phase = 0;
        model_last  = 1;
    endtask

    // Runs one command from an IDLE negedge with valids already driven; ends at the IDLE negedge after DONE
    task automatic exec(input int rid, input int n);
        logic [1:0] exp_rdy;
        logic       exp_seq, exp_busy, exp_done, exp_id;
        int         tdone, start, strobes, exp_ph;
        #1;
        exp_rdy = 2'b00;
        exp_rdy[rid] = 1'b1;
        n_cmp++;
        if ({req1_ready, req0_ready} !== exp_rdy) begin
            n_bad++;
            $display("FAIL accept_ready: got %b expected %b (req%0d n=%0d)", {req1_ready, req0_ready}, exp_rdy, rid, n);
        end
        @(posedge clk);
        #1;
        if (rid == 0) begin req0_valid = 1'b0; req0_cnt = CW'($urandom); end
        else          begin req1_valid = 1'b0; req1_cnt = CW'($urandom); end
        start = model_phase;
        tdone = (n == 0) ? 1 : 1 + n + (n - 1) * int'(D);
        for (int t = 1; t <= tdone + 1; t++) begin
            @(negedge clk);
            if (n == 0) strobes = 0;
            else begin
                strobes = (t - 1 + int'(D)) / int'(D + 1);
                if (strobes > n) strobes = n;
            end
            exp_seq  = (n > 0 && (t - 1) % int'(D + 1) == 0 && (t - 1) / int'(D + 1) < n) ? 1'b0 : 1'b1;
            exp_busy = (t <= tdone);
            exp_done = (t == tdone);
            exp_id   = (t == tdone) ? rid[0] : 1'b0;
            exp_ph   = (start + strobes) % 4;
            n_cmp++;
            if (seq_i !== exp_seq) begin
                n_bad++;
                $display("FAIL seq_i: t=%0d got %b expected %b (req%0d n=%0d)", t, seq_i, exp_seq, rid, n);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL busy: t=%0d got %b expected %b", t, busy, exp_busy);
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_bad++;
                $display("FAIL done: t=%0d got %b expected %b (req%0d n=%0d)", t, done, exp_done, rid, n);
            end
            n_cmp++;
            if (done_id !== exp_id) begin
                n_bad++;
                $display("FAIL done_id: t=%0d got %b expected %b", t, done_id, exp_id);
            end
            n_cmp++;
            if (int'(phase) !== exp_ph) begin
                n_bad++;
                $display("FAIL phase: t=%0d got %0d expected %0d", t, phase, exp_ph);
            end
            n_cmp++;
            if (phase_err !== 1'b0) begin
                n_bad++;
                $display("FAIL phase_err_clean: t=%0d got %b expected 0", t, phase_err);
            end
            if (t <= tdone) begin
                n_cmp++;
                if ({req1_ready, req0_ready} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL ready_busy: t=%0d got %b expected 00", t, {req1_ready, req0_ready});
                end
            end
        end
        model_phase = (start + n) % 4;
        model_last  = rid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_cnt = CW'($urandom);
        req1_cnt = CW'($urandom);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({seq_i, phase, busy, done, done_id, phase_err} !== {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got seq_i=%b phase=%0d busy=%b done=%b id=%b err=%b expected 1/0/0/0/0/0",
                     seq_i, phase, busy, done, done_id, phase_err);
        end
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        model_phase = 0;
        model_last  = 1;
    endtask

    task automatic test_basic();
        req0_valid = 1'b1;
        req0_cnt   = CW'(3);
        exec(0, 3);
    endtask

    task automatic test_wrap();
        apply_reset();
        req1_valid = 1'b1;
        req1_cnt   = CW'(5);
        exec(1, 5);
        n_cmp++;
        if (phase !== 2'd1) begin
            n_bad++;
            $display("FAIL wrap_phase: got %0d expected 1", phase);
        end
    endtask

    task automatic test_both();
        apply_reset();
        req0_valid = 1'b1;
        req0_cnt   = CW'(2);
        req1_valid = 1'b1;
        req1_cnt   = CW'(1);
        exec(0, 2);
        exec(1, 1);
    endtask

    task automatic test_zero();
        req0_valid = 1'b1;
        req0_cnt   = CW'(0);
        exec(0, 0);
    endtask

    task automatic test_rst_mid();
        req0_valid = 1'b1;
        req0_cnt   = CW'(4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1'b1;
        req1_cnt   = CW'(2);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({seq_i, phase, busy, done, done_id, phase_err} !== {1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got seq_i=%b phase=%0d busy=%b done=%b id=%b err=%b expected 1/0/0/0/0/0",
                     seq_i, phase, busy, done, done_id, phase_err);
        end
        n_cmp++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        rst = 1'b0;
        model_phase = 0;
        model_last  = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, busy, seq_i} !== 3'b001) begin
                n_bad++;
                $display("FAIL rst_mid_abort: cycle %0d got done/busy/seq_i=%b expected 001", i, {done, busy, seq_i});
            end
        end
        req0_valid = 1'b1;
        req0_cnt   = CW'(2);
        exec(0, 2);
    endtask

    task automatic test_random();
        logic p0, p1;
        int   c0, c1, w;
        p0 = 1'b0;
        p1 = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int it = 0; it < 12; it++) begin
            if (!p0 && $urandom_range(1, 0) == 1) begin p0 = 1'b1; c0 = $urandom_range(6, 0); end
            if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1'b1; c1 = $urandom_range(6, 0); end
            if (!p0 && !p1) begin p0 = 1'b1; c0 = $urandom_range(6, 0); end
            req0_valid = p0;
            req0_cnt   = CW'(c0);
            req1_valid = p1;
            req1_cnt   = CW'(c1);
            w = pick(p0, p1, model_last);
            if (w == 0) begin exec(0, c0); p0 = 1'b0; end
            else        begin exec(1, c1); p1 = 1'b0; end
        end
        if (p0) exec(0, c0);
        if (p1) exec(1, c1);
    endtask

    task automatic test_phase_check();
        logic exp_err;
`ifdef XYZ_CTRL_PHASE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        req0_valid = 1'b1;
        req0_cnt   = CW'(2);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        fb_bad = 1'b1;
        @(negedge clk);
        fb_bad = 1'b0;
        n_cmp++;
        if (phase_err !== exp_err) begin
            n_bad++;
            $display("FAIL phase_err_set: got %b expected %b", phase_err, exp_err);
        end
        for (int i = 0; i < 6; i++) @(negedge clk);
        n_cmp++;
        if (phase_err !== exp_err) begin
            n_bad++;
            $display("FAIL phase_err_sticky: got %b expected %b", phase_err, exp_err);
        end
        apply_reset();
        #1;
        n_cmp++;
        if (phase_err !== 1'b0) begin
            n_bad++;
            $display("FAIL phase_err_cleared: got %b expected 0", phase_err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        fb_bad     = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_cnt   = '0;
        req1_cnt   = '0;
        model_phase = 0;
        model_last  = 1;
        test_reset();
        test_basic();
        test_wrap();
        test_both();
        test_zero();
        test_rst_mid();
        test_random();
        test_phase_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
